// File: rtl/mor1kx_branch_predictor_pht_arbiter.sv
// Pattern history table port arbiter.
//
// The PHT is a single-port RAM of 2-bit saturating counters. Each cycle the
// port is given to exactly one of these users:
//   - a decode-stage lookup read,
//   - the read half of a training update (RD),
//   - the write half of a training update (WR),
//   - nobody (idle, all port outputs held at zero).
//
// Resolved branches are buffered in a 2-entry FIFO of {addr, taken}. The
// update FSM drains the FIFO with a read-modify-write (RD then WR) to the
// head entry's counter.
//
// Lookups normally win the port. An update steals it only in one of two
// cases: no lookup is pending, or the FIFO is full.
//
// The RD access happens in the same cycle that the FSM decides to leave
// IDLE. This keeps a full-queue drain to exactly two stalled lookup cycles.
// For that reason RD is a transient state: cur_state reports RD for that one
// cycle, while the registered state moves straight on to WR.
//
// Handshakes:
//   - lookup_req_i / lookup_stall_o: the requester holds lookup_req_i and
//     lookup_addr_i until a cycle with lookup_stall_o low. That cycle is the
//     grant. predict_valid_o / predict_taken_o follow one cycle later.
//   - update_req_i / update_full_o: the block accepts an update when
//     update_req_i is high and update_full_o is low. An update offered while
//     update_full_o is high is dropped and is not retried.
//
// Queued updates are never forwarded into predictions; a prediction may
// reflect a counter that is about to be trained.
module mor1kx_branch_predictor_pht_arbiter #(
    parameter int OPTION_PHT_AW = 6
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     lookup_req_i,
    input  logic [OPTION_PHT_AW-1:0] lookup_addr_i,
    output logic                     lookup_stall_o,
    output logic                     predict_valid_o,
    output logic                     predict_taken_o,

    input  logic                     update_req_i,
    input  logic [OPTION_PHT_AW-1:0] update_addr_i,
    input  logic                     update_taken_i,
    output logic                     update_full_o,

    output logic [OPTION_PHT_AW-1:0] pht_addr_o,
    output logic                     pht_we_o,
    output logic [1:0]               pht_wdata_o,
    input  logic [1:0]               pht_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    // Update FSM state
    state_t state_q;
    state_t state_d;
    state_t cur_state;

    // Update FIFO storage
    logic [OPTION_PHT_AW-1:0] fifo_addr_q  [2];
    logic                     fifo_taken_q [2];
    logic                     wr_ptr_q;
    logic                     wr_ptr_d;
    logic                     rd_ptr_q;
    logic                     rd_ptr_d;
    logic [1:0]               count_q;
    logic [1:0]               count_d;

    // Prediction pipeline register
    logic predict_valid_q;
    logic predict_valid_d;

    // Arbitration decisions for the current cycle
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     enter_rd;
    logic                     grant;
    logic                     push;
    logic                     pop;
    logic [OPTION_PHT_AW-1:0] head_addr;
    logic                     head_taken;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) begin
                res = cnt + 2'b01;
            end
        end else begin
            if (cnt != 2'b00) begin
                res = cnt - 2'b01;
            end
        end
        return res;
    endfunction

    assign fifo_full     = (count_q == 2'd2);
    assign fifo_empty    = (count_q == 2'd0);
    assign update_full_o = fifo_full;
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_taken    = fifo_taken_q[rd_ptr_q];

    // Arbitration: decide who owns the PHT port this cycle
    always_comb begin
        enter_rd  = 1'b0;
        grant     = 1'b0;
        cur_state = state_q;
        if (!rst) begin
            if (state_q == S_IDLE && !fifo_empty && (!lookup_req_i || fifo_full)) begin
                enter_rd = 1'b1;
            end
            if (state_q == S_IDLE && !enter_rd && lookup_req_i) begin
                grant = 1'b1;
            end
        end
        if (enter_rd) begin
            cur_state = S_RD;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> RD -> WR -> IDLE, with RD lasting one cycle
    always_comb begin
        state_d = S_IDLE;
        case (cur_state)
            S_IDLE:  state_d = S_IDLE;
            S_RD:    state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: PHT port mux, stall and prediction valid
    always_comb begin
        pht_addr_o     = '0;
        pht_we_o       = 1'b0;
        pht_wdata_o    = 2'b00;
        lookup_stall_o = 1'b0;
        if (!rst) begin
            case (cur_state)
                S_IDLE: begin
                    if (grant) begin
                        pht_addr_o = lookup_addr_i;
                    end
                end
                S_RD: begin
                    pht_addr_o = head_addr;
                end
                S_WR: begin
                    pht_addr_o  = head_addr;
                    pht_we_o    = 1'b1;
                    pht_wdata_o = sat_step(pht_rdata_i, head_taken);
                end
                default: begin
                    pht_addr_o = '0;
                end
            endcase
            lookup_stall_o = lookup_req_i && !grant;
        end
    end

    assign predict_valid_o = predict_valid_q && !rst;
    assign predict_taken_o = predict_valid_o && pht_rdata_i[1];

    // FIFO push/pop control
    always_comb begin
        push     = !rst && update_req_i && !fifo_full;
        pop      = !rst && (cur_state == S_WR);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage, written at the write pointer on a push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= update_addr_i;
            fifo_taken_q[wr_ptr_q] <= update_taken_i;
        end
    end

    // Prediction valid follows a granted lookup by one cycle
    always_comb begin
        predict_valid_d = grant;
    end

    // Prediction valid register
    always_ff @(posedge clk) begin
        if (rst) begin
            predict_valid_q <= 1'b0;
        end else begin
            predict_valid_q <= predict_valid_d;
        end
    end

endmodule

// File: tb/tb_mor1kx_branch_predictor_pht_arbiter.sv
module tb_mor1kx_branch_predictor_pht_arbiter;

  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          lookup_req_i;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_stall_o;
  logic          predict_valid_o;
  logic          predict_taken_o;
  logic          update_req_i;
  logic [AW-1:0] update_addr_i;
  logic          update_taken_i;
  logic          update_full_o;
  logic [AW-1:0] pht_addr_o;
  logic          pht_we_o;
  logic [1:0]    pht_wdata_o;
  logic [1:0]    pht_rdata_i;

  mor1kx_branch_predictor_pht_arbiter #(.OPTION_PHT_AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_req_i   (lookup_req_i),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_stall_o (lookup_stall_o),
    .predict_valid_o(predict_valid_o),
    .predict_taken_o(predict_taken_o),
    .update_req_i   (update_req_i),
    .update_addr_i  (update_addr_i),
    .update_taken_i (update_taken_i),
    .update_full_o  (update_full_o),
    .pht_addr_o     (pht_addr_o),
    .pht_we_o       (pht_we_o),
    .pht_wdata_o    (pht_wdata_o),
    .pht_rdata_i    (pht_rdata_i)
  );

  // ---------------- PHT RAM (read-first, 1-cycle read latency) ----------------
  function automatic logic [1:0] init_val(input int i);
    case (i)
      5:       return 2'b10;
      3:       return 2'b11;
      7:       return 2'b01;
      9:       return 2'b01;
      default: return 2'(i % 4);
    endcase
  endfunction

  logic       ram_init;
  logic [1:0] mem [64];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      pht_rdata_i <= 2'b00;
    end else begin
      if (pht_we_o) mem[pht_addr_o] <= pht_wdata_o;
      pht_rdata_i <= mem[pht_addr_o];
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending updates as a queue, golden counter array, and whether the
  // current cycle is the write half of a training access.
  int   mq_addr[$];
  int   mq_taken[$];
  int   golden[64];
  bit   m_in_wr;
  bit   m_prev_grant;
  int   m_prev_pt;

  int   e_stall, e_pv, e_pt, e_full, e_we, e_addr, e_wdata;
  bit   m_grant, m_start;

  function automatic int sat(input int c, input int t);
    if (t != 0) return (c + 1 > 3) ? 3 : c + 1;
    else        return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  task automatic model_expect(input bit r, input bit lreq, input int laddr);
    e_full  = (mq_addr.size() == 2) ? 1 : 0;
    e_stall = 0; e_pv = 0; e_pt = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    m_grant = 0; m_start = 0;
    if (!r) begin
      e_pv = m_prev_grant ? 1 : 0;
      e_pt = m_prev_grant ? m_prev_pt : 0;
      if (m_in_wr) begin
        e_addr  = mq_addr[0];
        e_we    = 1;
        e_wdata = sat(golden[mq_addr[0]], mq_taken[0]);
        e_stall = lreq;
      end else if (mq_addr.size() > 0 && (!lreq || e_full == 1)) begin
        m_start = 1;
        e_addr  = mq_addr[0];
        e_stall = lreq;
      end else if (lreq) begin
        m_grant = 1;
        e_addr  = laddr;
      end
    end
  endtask

  task automatic model_update(input bit r, input bit ureq, input int uaddr, input int ut,
                              input int laddr);
    if (r) begin
      mq_addr.delete();
      mq_taken.delete();
      m_in_wr      = 0;
      m_prev_grant = 0;
      m_prev_pt    = 0;
    end else begin
      m_prev_grant = m_grant;
      m_prev_pt    = m_grant ? (golden[laddr] >> 1) : 0;
      if (e_we == 1) begin
        golden[e_addr] = e_wdata;
        void'(mq_addr.pop_front());
        void'(mq_taken.pop_front());
      end
      if (ureq && e_full == 0) begin
        mq_addr.push_back(uaddr);
        mq_taken.push_back(ut);
      end
      m_in_wr = m_start;
    end
  endtask

  // ---------------- driver ----------------
  typedef struct {
    bit rst; bit lreq; int laddr; bit ureq; int uaddr; bit ut;
    int stall; int pv; int pt; int full; int we; int addr; int wdata;
  } vec_t;

  task automatic run_cycle(input vec_t v, input bit use_tab, input int idx);
    @(negedge clk);
    rst            = v.rst;
    lookup_req_i   = v.lreq;
    lookup_addr_i  = AW'(v.laddr);
    update_req_i   = v.ureq;
    update_addr_i  = AW'(v.uaddr);
    update_taken_i = v.ut;
    #1;
    model_expect(v.rst, v.lreq, v.laddr);
    chk("model_stall", int'(lookup_stall_o),  e_stall);
    chk("model_pv",    int'(predict_valid_o), e_pv);
    chk("model_pt",    int'(predict_taken_o), e_pt);
    chk("model_full",  int'(update_full_o),   e_full);
    chk("model_we",    int'(pht_we_o),        e_we);
    chk("model_addr",  int'(pht_addr_o),      e_addr);
    chk("model_wdata", int'(pht_wdata_o),     e_wdata);
    if (use_tab) begin
      chk($sformatf("tab%0d_stall", idx), int'(lookup_stall_o),  v.stall);
      chk($sformatf("tab%0d_pv", idx),    int'(predict_valid_o), v.pv);
      chk($sformatf("tab%0d_pt", idx),    int'(predict_taken_o), v.pt);
      chk($sformatf("tab%0d_full", idx),  int'(update_full_o),   v.full);
      chk($sformatf("tab%0d_we", idx),    int'(pht_we_o),        v.we);
      chk($sformatf("tab%0d_addr", idx),  int'(pht_addr_o),      v.addr);
      chk($sformatf("tab%0d_wdata", idx), int'(pht_wdata_o),     v.wdata);
    end
    model_update(v.rst, v.ureq, v.uaddr, v.ut, v.laddr);
  endtask

  // ---------------- directed table ----------------
  //          rst lreq la ureq ua ut | stall pv pt full we addr wdata
  vec_t tab[26];
  initial begin
    tab[0]  = '{1,1,5, 0,0,0,  0,0,0,0,0,0,0};  // reset forces outputs
    tab[1]  = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};  // post-reset idle
    tab[2]  = '{0,1,5, 0,0,0,  0,0,0,0,0,5,0};  // lookup 5 granted
    tab[3]  = '{0,0,0, 0,0,0,  0,1,1,0,0,0,0};  // PHT[5]=10 -> taken
    tab[4]  = '{0,0,0, 1,3,1,  0,0,0,0,0,0,0};  // push update 3 taken
    tab[5]  = '{0,0,0, 0,0,0,  0,0,0,0,0,3,0};  // RD 3
    tab[6]  = '{0,0,0, 0,0,0,  0,0,0,0,1,3,3};  // WR 3 saturates at 11
    tab[7]  = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};  // queue empty, idle
    tab[8]  = '{0,1,7, 1,0,0,  0,0,0,0,0,7,0};  // lookup 7 + push 0 NT
    tab[9]  = '{0,1,7, 1,9,1,  0,1,0,0,0,7,0};  // lookup 7 + push 9 T -> full
    tab[10] = '{0,1,7, 1,3,0,  1,1,0,1,0,0,0};  // full: RD 0, 3rd update dropped
    tab[11] = '{0,1,7, 0,0,0,  1,0,0,1,1,0,0};  // WR 0: 00 stays 00
    tab[12] = '{0,1,7, 0,0,0,  0,0,0,0,0,7,0};  // lookup granted again
    tab[13] = '{0,0,0, 0,0,0,  0,1,0,0,0,9,0};  // RD 9
    tab[14] = '{0,0,0, 0,0,0,  0,0,0,0,1,9,2};  // WR 9: 01 -> 10
    tab[15] = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};  // no third write
    tab[16] = '{0,0,0, 1,5,0,  0,0,0,0,0,0,0};  // push 5 NT
    tab[17] = '{1,0,0, 0,0,0,  0,0,0,0,0,0,0};  // reset in RD cycle
    tab[18] = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};  // queue gone
    tab[19] = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};
    tab[20] = '{0,0,0, 1,7,1,  0,0,0,0,0,0,0};  // push 7 T
    tab[21] = '{0,0,0, 0,0,0,  0,0,0,0,0,7,0};  // RD 7
    tab[22] = '{0,0,0, 1,7,1,  0,0,0,0,1,7,2};  // WR 7 01->10 with push
    tab[23] = '{0,0,0, 0,0,0,  0,0,0,0,0,7,0};  // RD 7 of queued entry
    tab[24] = '{0,0,0, 0,0,0,  0,0,0,0,1,7,3};  // WR 7 10->11
    tab[25] = '{0,0,0, 0,0,0,  0,0,0,0,0,0,0};
  end

  // ---------------- main sequence ----------------
  int n_writes;
  vec_t rv;

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    lookup_req_i = 0; lookup_addr_i = '0;
    update_req_i = 0; update_addr_i = '0; update_taken_i = 0;
    for (int i = 0; i < 64; i++) golden[i] = int'(init_val(i));
    m_in_wr = 0; m_prev_grant = 0; m_prev_pt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;

    for (int i = 0; i < 26; i++) run_cycle(tab[i], 1'b1, i);

    // Only the two accepted updates wrote address 0 and 9; address 3 kept 11
    // from the saturating write, address 5 untouched by the abandoned update.
    chk("mem3_after", int'(mem[3]), 3);
    chk("mem0_after", int'(mem[0]), 0);
    chk("mem9_after", int'(mem[9]), 2);
    chk("mem5_after", int'(mem[5]), 2);

    // Randomized traffic against the reference model
    n_writes = 0;
    for (int i = 0; i < 1500; i++) begin
      rv = '{default: 0};
      rv.rst   = ($urandom_range(0, 99) == 0);
      rv.lreq  = ($urandom_range(0, 99) < 55);
      rv.laddr = $urandom_range(0, 63);
      rv.ureq  = ($urandom_range(0, 99) < 45);
      rv.uaddr = $urandom_range(0, 15);
      rv.ut    = $urandom_range(0, 1);
      run_cycle(rv, 1'b0, i);
      if (e_we == 1) n_writes++;
    end

    // Drain and compare the whole table against the golden counters
    rv = '{default: 0};
    repeat (8) run_cycle(rv, 1'b0, 0);
    chk("drain_empty", int'(mq_addr.size()), 0);
    for (int i = 0; i < 64; i++) chk($sformatf("mem%0d_final", i), int'(mem[i]), golden[i]);
    if (n_writes == 0) chk("random_writes_seen", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
